rvv_rvs_issue_buf: RTL

Multi-lane in-order instruction buffer between the scalar core's vector-instruction issue port and the backend command queue (`insts_valid_rvs2cq` / `insts_rvs2cq` / `insts_ready_cq2rvs`). Each cycle it accepts up to `LANES` instructions from the scalar side and presents up to `LANES` of the oldest buffered instructions downstream. It decouples scalar issue from command-queue backpressure and supports a trap-driven flush.

---
 rtl/rvv_backend_pkg.sv | 14 +
 rtl/rvv_issue_buf_mem.sv | 43 ++++
 rtl/rvv_rvs_issue_buf.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rvv_backend_pkg.sv
// Shared backend types and defaults for the vector-instruction issue path.
package rvv_backend_pkg;

    // Default issue width and buffer depth for rvv_rvs_issue_buf
    localparam int ISSUE_LANES     = 2;
    localparam int ISSUE_BUF_DEPTH = 8;

    // Vector command handed from the scalar core to the backend command queue
    typedef struct packed {
        logic [31:0] insn;      // raw vector instruction encoding
        logic [31:0] rs1_data;  // scalar operand captured at issue
    } RVVCmd;

endpackage

// File: rtl/rvv_issue_buf_mem.sv
// Register file for the issue buffer: LANES write ports and LANES read
// ports, each addressed as base + lane with natural modulo-DEPTH wrap.
// Contents are deliberately not reset; occupancy lives in the pointers.
module rvv_issue_buf_mem
    import rvv_backend_pkg::*;
#(
    parameter int  DEPTH  = ISSUE_BUF_DEPTH,
    parameter int  LANES  = ISSUE_LANES,
    parameter type INST_T = RVVCmd
) (
    input  logic                       clk,
    input  logic [LANES-1:0]           wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_base,
    input  INST_T [LANES-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    output INST_T [LANES-1:0]          rd_data
);

    localparam int AW = $clog2(DEPTH);

    INST_T          mem [DEPTH];
    logic [AW-1:0]  wr_idx [LANES];
    logic [AW-1:0]  rd_idx [LANES];

    // Per-lane entry addresses and read mux; AW-bit sums wrap at DEPTH
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wr_idx[i]  = wr_base + AW'(i);
            rd_idx[i]  = rd_base + AW'(i);
            rd_data[i] = mem[rd_idx[i]];
        end
    end

    // Lane writes; lanes always target distinct entries since LANES <= DEPTH
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx[i]] <= wr_data[i];
            end
        end
    end

endmodule

// File: rtl/rvv_rvs_issue_buf.sv
// Multi-lane in-order issue buffer between scalar vector issue and the
// backend command queue. Optional macro RVV_ISSUE_BUF_BYPASS_EN lets
// accepted inputs fill empty output lanes in the same cycle.
//
// Handshake: on each side lane i transfers when valid[i] and ready[i] are
// both high at the rising edge. Valid and ready masks are prefix masks;
// on the output side only the leading run of (valid & ready) is consumed,
// so a non-prefix out_ready is truncated at its first 0.
module rvv_rvs_issue_buf
    import rvv_backend_pkg::*;
#(
    parameter int  LANES  = ISSUE_LANES,
    parameter int  DEPTH  = ISSUE_BUF_DEPTH,
    parameter type INST_T = RVVCmd
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         in_valid,
    input  INST_T [LANES-1:0]        in_inst,
    output logic [LANES-1:0]         in_ready,
    output logic [LANES-1:0]         out_valid,
    output INST_T [LANES-1:0]        out_inst,
    input  logic [LANES-1:0]         out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]     rd_ptr;
    logic [CW-1:0]     wr_ptr;
    logic [CW-1:0]     free_slots;
    logic [CW-1:0]     push_n;
    logic [CW-1:0]     pop_n;
    logic [LANES-1:0]  accept;
    logic [LANES-1:0]  wr_en;
    logic              run;
    INST_T [LANES-1:0] mem_rd;

    // Occupancy from the wrap-bit pointers; full when difference is DEPTH
    assign count      = wr_ptr - rd_ptr;
    assign free_slots = CW'(DEPTH) - count;

    // Handshake decode: free-slot ready, push/pop counts, output lanes
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_inst  = mem_rd;
        push_n    = '0;
        pop_n     = '0;
        run       = 1'b1;
        // Ready ignores same-cycle pops so it never depends on out_ready
        for (int i = 0; i < LANES; i++) begin
            in_ready[i] = !flush && (int'(free_slots) > i);
        end
        accept = in_valid & in_ready;
        for (int i = 0; i < LANES; i++) begin
            push_n = push_n + CW'(accept[i]);
        end
`ifdef RVV_ISSUE_BUF_BYPASS_EN
        // Buffered entries first, then accepted inputs fill the empty lanes
        for (int i = 0; i < LANES; i++) begin
            if (int'(count) > i) begin
                out_valid[i] = 1'b1;
                out_inst[i]  = mem_rd[i];
            end else if ((i - int'(count)) < int'(push_n)) begin
                out_valid[i] = 1'b1;
                out_inst[i]  = in_inst[i - int'(count)];
            end
        end
`else
        for (int i = 0; i < LANES; i++) begin
            out_valid[i] = int'(count) > i;
        end
`endif
        // Consume only the leading run of accepted output lanes
        for (int i = 0; i < LANES; i++) begin
            run   = run & out_valid[i] & out_ready[i];
            pop_n = pop_n + CW'(run);
        end
`ifdef RVV_ISSUE_BUF_BYPASS_EN
        // Inputs handed straight through this cycle never touch memory
        for (int i = 0; i < LANES; i++) begin
            wr_en[i] = accept[i] && ((int'(count) + i) >= int'(pop_n));
        end
`else
        wr_en = accept;
`endif
    end

    // Pointer update; flush empties the buffer by catching rd_ptr up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_n;
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                rd_ptr <= rd_ptr + pop_n;
            end
        end
    end

    rvv_issue_buf_mem #(
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .INST_T (INST_T)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (wr_ptr[AW-1:0]),
        .wr_data (in_inst),
        .rd_base (rd_ptr[AW-1:0]),
        .rd_data (mem_rd)
    );

endmodule
